bg7_fetch: RTL

Mode 7 VRAM fetch and pixel stage of the PPU. Consumes per-dot 10-bit VRAM.X/Y coordinates and the screen-over flag from the mode 7 coordinate stage. Performs the map fetch (tile number, VRAM low bytes) and the data fetch (pixel colour, VRAM high bytes), applies the M7SEL screen-over rule and EXTBG split, and emits one registered BG pixel per dot to the priority/compositing logic.

---
 rtl/bg7_fetch.sv | 90 +++++++++
 1 files changed

// File: rtl/bg7_fetch.sv
// bg7_fetch: mode 7 VRAM fetch and pixel stage (map fetch, data fetch, screen-over, EXTBG)
//   clk          PPU master clock
//   reset        asynchronous reset, active-low
//   dot_en       one-clock pulse per dot; every stage advances only on it
//   flush        clears all valid bits; wins over dot_en
//   m7sel[3:2]   screen-over mode: 0x wrap, 10 transparent, 11 tile 0
//   extbg        1 = colour bit 7 becomes the BG2 priority
//   in_*         per-dot VRAM.X/Y coordinate, over flag and valid
//   vram_l_addr  map fetch word address      (rdata_l valid 1 clk later)
//   vram_h_addr  pixel data fetch word address (rdata_h valid 1 clk later)
//   px_*         registered BG pixel to compositing
module bg7_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        dot_en,
    input  logic        flush,
    input  logic [3:0]  m7sel,
    input  logic        extbg,
    input  logic        in_valid,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    input  logic        in_over,
    output logic [14:0] vram_l_addr,
    output logic [14:0] vram_h_addr,
    input  logic [7:0]  vram_rdata_l,
    input  logic [7:0]  vram_rdata_h,
    output logic        px_valid,
    output logic [7:0]  px_color,
    output logic        px_prio
);
    logic [9:0] r_a_x;
    logic [9:0] r_a_y;
    logic       r_a_over;
    logic       r_a_v;
    logic [7:0] r_b_tile;
    logic [2:0] r_b_fx;
    logic [2:0] r_b_fy;
    logic       r_b_over;
    logic       r_b_v;
    logic       r_px_valid;
    logic [7:0] r_px_color;
    logic       r_px_prio;
    logic       w_force;
    logic       w_clear;
    logic [1:0] w_unused;
    assign w_unused = m7sel[1:0];
    // out-of-plane coordinate in tile-0 mode: fetch address 0, tile muxed to 0
    assign w_force = r_a_over && (m7sel[3:2] == 2'b11);
    // out-of-plane coordinate in transparent mode: pixel forced to 0
    assign w_clear = r_b_over && (m7sel[3:2] == 2'b10);
    assign vram_l_addr = w_force ? 15'd0 : {1'b0, r_a_y[9:3], r_a_x[9:3]};
    assign vram_h_addr = {1'b0, r_b_tile, r_b_fy, r_b_fx};
    assign px_valid = r_px_valid;
    assign px_color = r_px_color;
    assign px_prio  = r_px_prio;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_x      <= '0;
            r_a_y      <= '0;
            r_a_over   <= 1'b0;
            r_a_v      <= 1'b0;
            r_b_tile   <= '0;
            r_b_fx     <= '0;
            r_b_fy     <= '0;
            r_b_over   <= 1'b0;
            r_b_v      <= 1'b0;
            r_px_valid <= 1'b0;
            r_px_color <= '0;
            r_px_prio  <= 1'b0;
        end else if (flush) begin
            // only valid bits are cleared; data registers keep their values
            r_a_v      <= 1'b0;
            r_b_v      <= 1'b0;
            r_px_valid <= 1'b0;
        end else if (dot_en) begin
            r_a_x      <= in_x;
            r_a_y      <= in_y;
            r_a_over   <= in_over;
            r_a_v      <= in_valid;
            r_b_tile   <= w_force ? 8'h00 : vram_rdata_l;
            r_b_fx     <= r_a_x[2:0];
            r_b_fy     <= r_a_y[2:0];
            r_b_over   <= r_a_over;
            r_b_v      <= r_a_v;
            r_px_valid <= r_b_v;
            r_px_color <= w_clear ? 8'h00 : extbg ? {1'b0, vram_rdata_h[6:0]} : vram_rdata_h;
            r_px_prio  <= !w_clear && extbg && vram_rdata_h[7];
        end
    end
endmodule
